// File: rtl/uart_rx_if.sv
// Purpose : receive-side bundle between the UART receiver and its byte consumer.
// Latency : n/a (wires only).
// Backpressure: rx_ack from the consumer releases the held byte; no stall of the line.
// Signals:
//   serial_rx     - raw serial line (idle high, 8N1, LSB first)
//   rx_ack        - consumer acknowledge, clears rx_valid
//   rx_byte       - last correctly framed byte
//   rx_valid      - rx_byte holds an unacknowledged byte (level)
//   overrun       - one-cycle pulse, byte delivered over an unacknowledged one
//   framing_error - one-cycle pulse, stop bit sampled low
interface uart_rx_if;
  logic       serial_rx;
  logic       rx_ack;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       overrun;
  logic       framing_error;

  // Receiver side.
  modport slave (
    input  serial_rx,
    input  rx_ack,
    output rx_byte,
    output rx_valid,
    output overrun,
    output framing_error
  );

  // Line driver / byte consumer side.
  modport master (
    output serial_rx,
    output rx_ack,
    input  rx_byte,
    input  rx_valid,
    input  overrun,
    input  framing_error
  );
endinterface

// File: rtl/uart_rx.sv
// Purpose : 8N1 UART receiver with a one-byte holding register and level valid.
// Latency : byte valid 96 cycles after the start-bit fall at CLOCK_DIV_MAX=9 (+2 with sync).
// Backpressure: none on the line; an unacknowledged byte is overwritten and overrun pulses.
// Ports:
//   clock_i   - single clock, all state on the rising edge
//   reset_n_i - synchronous active-low reset
//   bus       - uart_rx_if.slave (serial_rx, rx_ack in; rx_byte, rx_valid,
//               overrun, framing_error out)
// Parameter CLOCK_DIV_MAX: bit period is CLOCK_DIV_MAX+1 cycles (3 or more).
// Optional macro UART_RX_SYNC_EN: two-flop synchronizer on serial_rx (+2 cycles).
module uart_rx #(
  parameter int CLOCK_DIV_MAX = 9
) (
  input  logic      clock_i,
  input  logic      reset_n_i,
  uart_rx_if.slave  bus
);

  localparam int CW = $clog2(CLOCK_DIV_MAX + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLOCK_DIV_MAX);
  localparam logic [CW-1:0] DIV_HALF = CW'(CLOCK_DIV_MAX / 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic [2:0]      bit_idx_q;
  logic [2:0]      bit_idx_d;
  logic [7:0]      shift_q;
  logic [7:0]      rx_byte_q;
  logic            rx_valid_q;
  logic            overrun_q;
  logic            framing_error_q;
  logic            rx_in;

`ifdef UART_RX_SYNC_EN
  // Two-flop synchronizer; flops come out of reset at the idle level so a
  // reset never looks like a start bit.
  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= bus.serial_rx;
      sync2_q <= sync1_q;
    end
  end

  assign rx_in = sync2_q;
`else
  assign rx_in = bus.serial_rx;
`endif

  assign cnt_d     = cnt_q + CW'(1);
  assign bit_idx_d = bit_idx_q + 3'd1;

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      bit_idx_q       <= 3'd0;
      shift_q         <= 8'h00;
      rx_byte_q       <= 8'h00;
      rx_valid_q      <= 1'b0;
      overrun_q       <= 1'b0;
      framing_error_q <= 1'b0;
    end else begin
      overrun_q       <= 1'b0;
      framing_error_q <= 1'b0;

      // Acknowledge clears the holding register; a delivery in the same cycle
      // (STOP branch below) overrides this because its assignment comes later.
      if (rx_valid_q && bus.rx_ack) begin
        rx_valid_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (!rx_in) begin
            state_q <= S_START;
          end
        end

        S_START: begin
          // Mid-bit check of the start bit rejects short glitches.
          if (cnt_q == DIV_HALF) begin
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            state_q   <= rx_in ? S_IDLE : S_DATA;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        S_DATA: begin
          if (cnt_q == DIV_LAST) begin
            cnt_q     <= '0;
            shift_q   <= {rx_in, shift_q[7:1]};
            bit_idx_q <= bit_idx_d;  // wraps back to 0 after the 8th bit
            if (bit_idx_q == 3'd7) begin
              state_q <= S_STOP;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end

        S_STOP: begin
          if (cnt_q == DIV_LAST) begin
            cnt_q <= '0;
            if (rx_in) begin
              rx_byte_q  <= shift_q;
              rx_valid_q <= 1'b1;
              overrun_q  <= rx_valid_q && !bus.rx_ack;
              state_q    <= S_IDLE;
            end else begin
              framing_error_q <= 1'b1;
              state_q         <= S_BREAK;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end

        S_BREAK: begin
          // Line held low after a bad stop bit: wait for idle before hunting
          // for the next start bit.
          cnt_q <= '0;
          if (rx_in) begin
            state_q <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.rx_byte       = rx_byte_q;
  assign bus.rx_valid      = rx_valid_q;
  assign bus.overrun       = overrun_q;
  assign bus.framing_error = framing_error_q;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLOCK_DIV_MAX, default 9, bit period = CLOCK_DIV_MAX+1 clock cycles (minimum 3).
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset, sampled on rising edge of clock.
REQ-004 serial_rx  input  1  asynchronous serial line; idle high; 8N1, LSB first.
REQ-005 rx_byte  output  8  last correctly framed data byte.
REQ-006 rx_valid  output  1  rx_byte holds an unacknowledged byte; level, held until acknowledged.
REQ-007 rx_ack  input  1  consumer acknowledge; clears rx_valid.
REQ-008 overrun  output  1  one-cycle pulse: a new byte was delivered while rx_valid=1 and rx_ack=0.
REQ-009 framing_error  output  1  one-cycle pulse: stop bit sampled low.

Function
REQ-010 rx_in SHALL be the internal sampled line: serial_rx, or its synchronized copy per REQ-030.
REQ-011 States SHALL be IDLE, START, DATA, STOP, BREAK; one cycle counter (0..CLOCK_DIV_MAX) and one 3-bit bit index.
REQ-012 IDLE: rx_in=0 -> START with counter=0; else stay IDLE.
REQ-013 START: counter increments; at counter==CLOCK_DIV_MAX/2 (integer division): rx_in=1 -> IDLE (glitch rejected, nothing reported); rx_in=0 -> DATA, counter=0, bit index=0.
REQ-014 DATA: counter increments; at counter==CLOCK_DIV_MAX, rx_in SHALL shift into the MSB of an 8-bit shift register (right shift), counter=0, and bit index SHALL increment; after the 8th sample -> STOP.
REQ-015 STOP: at counter==CLOCK_DIV_MAX sample rx_in; 1 -> rx_byte<=shift register, rx_valid<=1, -> IDLE; 0 -> framing_error pulse, rx_byte/rx_valid unchanged, -> BREAK.
REQ-016 BREAK: stay until rx_in=1, then -> IDLE; no start detection while in BREAK.
REQ-017 Timing: with the first cycle rx_in=0 in IDLE at edge 0, the start sample SHALL occur at edge 1+CLOCK_DIV_MAX/2, and each later sample CLOCK_DIV_MAX+1 edges after the previous one (default: 5, 15..85, stop at 95; rx_valid high from edge 96).
REQ-018 rx_ack=1 while rx_valid=1 and no delivery in the same cycle SHALL clear rx_valid on the next edge; rx_ack while rx_valid=0 SHALL be ignored.
REQ-019 Delivery and rx_ack in the same cycle: new byte loaded, rx_valid stays 1, no overrun.
REQ-020 Delivery with rx_valid=1, rx_ack=0: rx_byte overwritten with the new byte, rx_valid stays 1, overrun pulses for exactly one cycle.
REQ-021 overrun and framing_error SHALL never be high for more than one consecutive cycle per event.
REQ-022 Back-to-back frames (start bit immediately after stop bit) SHALL be received without loss.

Reset
REQ-023 reset_n=0 SHALL force, on the next edge: state IDLE, counter 0, bit index 0, shift register 0x00.
REQ-024 Output reset values: rx_byte=0x00, rx_valid=0, overrun=0, framing_error=0.
REQ-025 Synchronizer flops SHALL reset to 1 (idle line).
REQ-026 Reset mid-frame SHALL discard the partial byte; reception restarts only on a new falling edge after reset_n=1.

Configuration
REQ-030 Macro UART_RX_SYNC_EN defined: serial_rx passes through a two-flop synchronizer before use as rx_in, adding exactly 2 cycles to all REQ-017 timings (default rx_valid at edge 98 relative to the serial_rx fall). Not defined: rx_in=serial_rx directly, timings exactly as in REQ-017.

Verification (CLOCK_DIV_MAX=9, macro undefined unless stated)
REQ-040 Frame 0x41 (start, 1,0,0,0,0,0,1,0, stop) at 10 cycles/bit -> rx_byte=0x41, rx_valid rises 96 cycles after the falling edge, no error pulses; repeat with UART_RX_SYNC_EN -> 98 cycles.
REQ-041 serial_rx low for 3 cycles, then high -> no rx_valid, no framing_error, state back to IDLE.
REQ-042 Frame 0x55 with stop bit low, line then held low 200 cycles, then high -> exactly one framing_error pulse, rx_valid stays 0, next frame 0xA5 received correctly.
REQ-043 Frames 0x12 then 0x34 back-to-back, rx_ack held 0 -> rx_byte=0x34, rx_valid=1, one overrun pulse; then rx_ack one cycle -> rx_valid=0.
REQ-044 rx_ack asserted in the exact cycle the second byte is delivered -> rx_valid stays 1, rx_byte=new byte, no overrun.
REQ-045 reset_n low for 1 cycle during bit 4 of frame 0xFF -> all outputs at reset values, no delivery; following frame 0x3C -> rx_byte=0x3C.
